// File: rtl/reed_solomon_decoder_line_unpacker.sv
// Line unpacker between the decoder requestor and the RS decoder core.
// Buffers incoming cache lines in a small FIFO and serialises the active line
// into SYM_W-bit symbols, little-endian, with sop/eop codeword framing
// every CW_LEN symbols, independent of line boundaries.
module reed_solomon_decoder_line_unpacker #(
   parameter int unsigned LINE_W    = 512,
   parameter int unsigned SYM_W     = 8,
   parameter int unsigned CW_LEN    = 255,
   parameter int unsigned BUF_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         cw_start,
   input  logic [LINE_W-1:0]            line_data,
   input  logic                         line_valid,
   output logic [SYM_W-1:0]             sym_data,
   output logic                         sym_valid,
   input  logic                         sym_ready,
   output logic                         sym_sop,
   output logic                         sym_eop,
   output logic [31:0]                  cw_count,
   output logic                         overflow,
   output logic [$clog2(BUF_DEPTH):0]   buf_level
);

   localparam int unsigned SPL   = LINE_W / SYM_W;
   localparam int unsigned IDX_W = $clog2(SPL);
   localparam int unsigned AW    = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   typedef enum logic {S_EMPTY, S_SHIFT} state_t;

   state_t              state_q, state_d;
   logic [LINE_W-1:0]   mem_q [BUF_DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    level_q, level_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [15:0]         sym_cnt_q, sym_cnt_d;
   logic [31:0]         cw_count_q, cw_count_d;
   logic                overflow_q, overflow_d;

   logic                fifo_empty, fifo_full;
   logic                xfer, last_sym, at_eop;
   logic                pop, push, wr_en;

   // Handshake and FIFO status decode
   always_comb begin
      fifo_empty = (level_q == '0);
      fifo_full  = (level_q == CNT_W'(BUF_DEPTH));
      xfer       = sym_valid & sym_ready;
      last_sym   = (idx_q == IDX_W'(SPL - 1));
      at_eop     = (sym_cnt_q == 16'(CW_LEN - 1));
      // pop refills an idle line register, or chains the next line on the
      // final symbol so back-to-back lines stream without a bubble
      pop        = ~cw_start & ~fifo_empty & ((state_q == S_EMPTY) | (xfer & last_sym));
      // a pop in the same edge frees a slot, so a full FIFO still accepts
      push       = ~cw_start & line_valid & (~fifo_full | pop);
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_EMPTY;
      else          state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      if (cw_start) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: if (!fifo_empty) state_d = S_SHIFT;
            S_SHIFT: if (xfer && last_sym && fifo_empty) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
         endcase
      end
   end

   // FSM outputs: symbol presentation and framing flags
   always_comb begin
      sym_valid = (state_q == S_SHIFT);
      sym_data  = sym_valid ? line_q[int'(idx_q) * SYM_W +: SYM_W] : '0;
      sym_sop   = sym_valid & (sym_cnt_q == '0);
      sym_eop   = sym_valid & at_eop;
   end

   // Datapath next-state: FIFO pointers, line register, framing counters
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      line_d     = line_q;
      idx_d      = idx_q;
      sym_cnt_d  = sym_cnt_q;
      cw_count_d = cw_count_q;
      overflow_d = overflow_q;
      wr_en      = 1'b0;
      if (cw_start) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         idx_d      = '0;
         sym_cnt_d  = '0;
         cw_count_d = '0;
         overflow_d = 1'b0;
      end else begin
         if (pop) begin
            line_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
            idx_d    = '0;
         end else if (xfer) begin
            idx_d = idx_q + IDX_W'(1);
         end
         if (push) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (line_valid && !push) overflow_d = 1'b1;
         level_d = level_q + CNT_W'(push) - CNT_W'(pop);
         if (xfer) begin
            if (at_eop) begin
               sym_cnt_d  = '0;
               cw_count_d = cw_count_q + 32'd1;
            end else begin
               sym_cnt_d = sym_cnt_q + 16'd1;
            end
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         line_q     <= '0;
         idx_q      <= '0;
         sym_cnt_q  <= '0;
         cw_count_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         line_q     <= line_d;
         idx_q      <= idx_d;
         sym_cnt_q  <= sym_cnt_d;
         cw_count_q <= cw_count_d;
         overflow_q <= overflow_d;
      end
   end

   // Line storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= line_data;
   end

   assign cw_count  = cw_count_q;
   assign overflow  = overflow_q;
   assign buf_level = level_q;

endmodule

// File: tb/tb_reed_solomon_decoder_line_unpacker.sv
// Scoreboard bench for the line unpacker. A queue-based reference model
// tracks held lines and the expected symbol stream; a negedge monitor
// compares every transferred symbol and the status outputs.
module tb_reed_solomon_decoder_line_unpacker;

   localparam int unsigned LINE_W    = 512;
   localparam int unsigned SYM_W     = 8;
   localparam int unsigned CW_LEN    = 255;
   localparam int unsigned BUF_DEPTH = 4;
   localparam int unsigned SPL       = LINE_W / SYM_W;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              cw_start = 1'b0;
   logic [LINE_W-1:0] line_data = '0;
   logic              line_valid = 1'b0;
   logic [SYM_W-1:0]  sym_data;
   logic              sym_valid;
   logic              sym_ready = 1'b0;
   logic              sym_sop;
   logic              sym_eop;
   logic [31:0]       cw_count;
   logic              overflow;
   logic [2:0]        buf_level;

   reed_solomon_decoder_line_unpacker #(
      .LINE_W(LINE_W), .SYM_W(SYM_W), .CW_LEN(CW_LEN), .BUF_DEPTH(BUF_DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .cw_start(cw_start),
      .line_data(line_data), .line_valid(line_valid),
      .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
      .sym_sop(sym_sop), .sym_eop(sym_eop), .cw_count(cw_count),
      .overflow(overflow), .buf_level(buf_level)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       sop;
      logic       eop;
   } sym_t;

   int checks = 0;
   int errors = 0;

   // reference model state
   sym_t              exp_q[$];
   logic [LINE_W-1:0] m_fifo[$];
   bit                m_act = 1'b0;
   int                m_idx = 0;
   bit                m_ov = 1'b0;
   int                m_tx = 0;
   int                m_pos = 0;
   bit                m_flushed = 1'b0;

   // monitor history for stall stability
   bit                p_hold = 1'b0;
   logic [9:0]        p_val = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      m_fifo.delete();
      exp_q.delete();
      m_act     = 1'b0;
      m_idx     = 0;
      m_ov      = 1'b0;
      m_tx      = 0;
      m_pos     = 0;
      m_flushed = 1'b1;
   endfunction

   // every accepted line contributes 64 symbols; framing follows stream position
   function automatic void enqueue_line(input logic [LINE_W-1:0] l);
      sym_t s;
      for (int i = 0; i < int'(SPL); i++) begin
         s.d   = l[i*8 +: 8];
         s.sop = (m_pos == 0);
         s.eop = (m_pos == int'(CW_LEN) - 1);
         exp_q.push_back(s);
         m_pos = (m_pos + 1) % int'(CW_LEN);
      end
   endfunction

   always @(negedge reset_n) model_clear();

   // reference model: one step per clock edge
   always @(posedge clk) begin
      bit mx, mp;
      if (reset_n) begin
         if (cw_start) begin
            model_clear();
         end else begin
            mx = m_act && sym_ready;
            mp = (m_fifo.size() > 0) && (!m_act || (mx && m_idx == int'(SPL) - 1));
            if (mx) begin
               m_tx++;
               m_idx++;
               if (m_idx == int'(SPL)) m_act = 1'b0;
            end
            if (line_valid) begin
               if (m_fifo.size() < int'(BUF_DEPTH) || mp) begin
                  m_fifo.push_back(line_data);
                  enqueue_line(line_data);
               end else begin
                  m_ov = 1'b1;
               end
            end
            if (mp) begin
               void'(m_fifo.pop_front());
               m_act = 1'b1;
               m_idx = 0;
            end
         end
      end
   end

   // monitor: compare status and pop the scoreboard on each transfer
   always @(negedge clk) begin
      sym_t s;
      chk("sym_valid", 64'(sym_valid), 64'(m_act));
      chk("buf_level", 64'(buf_level), 64'(m_fifo.size()));
      chk("overflow", 64'(overflow), 64'(m_ov));
      chk("cw_count", 64'(cw_count), 64'(m_tx / int'(CW_LEN)));
      if (!reset_n) begin
         chk("rst_sym_data", 64'(sym_data), 64'(0));
         chk("rst_sop_eop", 64'({sym_sop, sym_eop}), 64'(0));
      end
      if (p_hold && !m_flushed)
         chk("stall_stable", 64'({sym_data, sym_sop, sym_eop}), 64'(p_val));
      m_flushed = 1'b0;
      if (sym_valid && sym_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sym_extra: got %0h expected no symbol at %0t", sym_data, $time);
         end else begin
            s = exp_q.pop_front();
            chk("sym_data", 64'(sym_data), 64'(s.d));
            chk("sym_sop", 64'(sym_sop), 64'(s.sop));
            chk("sym_eop", 64'(sym_eop), 64'(s.eop));
         end
      end
      p_hold = sym_valid && !sym_ready;
      p_val  = {sym_data, sym_sop, sym_eop};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < int'(LINE_W / 32); i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [LINE_W-1:0] ramp_line(input int base);
      logic [LINE_W-1:0] l;
      for (int i = 0; i < int'(SPL); i++) l[i*8 +: 8] = 8'((base + i) % 256);
      return l;
   endfunction

   task automatic send_line(input logic [LINE_W-1:0] l);
      line_data  = l;
      line_valid = 1'b1;
      tick();
      line_valid = 1'b0;
   endtask

   initial begin
      // reset
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // one ramp line, free-flowing
      sym_ready = 1'b1;
      send_line(ramp_line(0));
      repeat (80) tick();

      // four back-to-back lines crossing a codeword boundary
      for (int k = 0; k < 4; k++) send_line(ramp_line(k * 64));
      repeat (300) tick();

      // 1,0,0,1 ready pattern during a line
      for (int c = 0; c < 300; c++) begin
         sym_ready = (c % 4 == 0) || (c % 4 == 3);
         if (c == 0) begin
            line_data  = rand_line();
            line_valid = 1'b1;
         end else begin
            line_valid = 1'b0;
         end
         tick();
      end

      // fill beyond capacity with the sink stalled, then drain
      sym_ready = 1'b0;
      for (int k = 0; k < 6; k++) send_line(rand_line());
      repeat (5) tick();
      chk("full_level", 64'(buf_level), 64'(BUF_DEPTH));
      chk("full_overflow", 64'(overflow), 64'(1));
      sym_ready = 1'b1;
      repeat (400) tick();
      chk("drain_empty", 64'(exp_q.size()), 64'(0));

      // cw_start mid-codeword with overflow set and a colliding line
      sym_ready = 1'b0;
      for (int k = 0; k < 6; k++) send_line(rand_line());
      sym_ready = 1'b1;
      repeat (100) tick();
      cw_start   = 1'b1;
      line_data  = rand_line();
      line_valid = 1'b1;
      tick();
      cw_start   = 1'b0;
      line_valid = 1'b0;
      chk("cws_valid", 64'(sym_valid), 64'(0));
      chk("cws_level", 64'(buf_level), 64'(0));
      chk("cws_cw_count", 64'(cw_count), 64'(0));
      chk("cws_overflow", 64'(overflow), 64'(0));
      send_line(rand_line());
      repeat (80) tick();

      // randomized traffic with occasional restarts
      for (int c = 0; c < 3000; c++) begin
         sym_ready  = ($urandom_range(0, 99) < 70);
         line_valid = ($urandom_range(0, 99) < 2);
         line_data  = rand_line();
         cw_start   = ($urandom_range(0, 999) < 2);
         tick();
      end
      cw_start   = 1'b0;
      line_valid = 1'b0;
      sym_ready  = 1'b1;
      repeat (400) tick();

      // asynchronous reset mid-line
      sym_ready = 1'b0;
      for (int k = 0; k < 6; k++) send_line(rand_line());
      sym_ready = 1'b1;
      repeat (10) tick();
      chk("pre_rst_valid", 64'(sym_valid), 64'(1));
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 64'(sym_valid), 64'(0));
      chk("arst_sop_eop", 64'({sym_sop, sym_eop}), 64'(0));
      chk("arst_overflow", 64'(overflow), 64'(0));
      chk("arst_cw_count", 64'(cw_count), 64'(0));
      chk("arst_level", 64'(buf_level), 64'(0));
      tick();
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 2; k++) send_line(ramp_line(k * 64 + 7));
      repeat (200) tick();
      chk("final_empty", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
